// File: rtl/rgb_hsv_stream_if.sv
// Pixel stream bundle for rgb_hsv_stream: RGB input side, HSV output side.
// Threshold inputs and out_mask exist only when HSV_MASK_EN is defined.
interface rgb_hsv_stream_if #(
  parameter int DATA_W = 8,
  parameter int USER_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_g;
  logic [DATA_W-1:0] in_b;
  logic [USER_W-1:0] in_user;
  logic              out_valid;
  logic              out_ready;
  logic [8:0]        out_h;
  logic [DATA_W-1:0] out_s;
  logic [DATA_W-1:0] out_v;
  logic [USER_W-1:0] out_user;
`ifdef HSV_MASK_EN
  logic [8:0]        th_h_lo;
  logic [8:0]        th_h_hi;
  logic [DATA_W-1:0] th_s_lo;
  logic [DATA_W-1:0] th_v_lo;
  logic              out_mask;
`endif

  modport master (
    output in_valid, in_r, in_g, in_b, in_user, out_ready,
    input  in_ready, out_valid, out_h, out_s, out_v, out_user
`ifdef HSV_MASK_EN
    , output th_h_lo, th_h_hi, th_s_lo, th_v_lo
    , input  out_mask
`endif
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_user, out_ready,
    output in_ready, out_valid, out_h, out_s, out_v, out_user
`ifdef HSV_MASK_EN
    , input  th_h_lo, th_h_hi, th_s_lo, th_v_lo
    , output out_mask
`endif
  );
endinterface

// File: rtl/rgb_hsv_stream.sv
// Pipelined RGB->HSV converter: min/max stage, DATA_W lock-step restoring divider stages, hue assembly.
// Optional HSV_MASK_EN macro adds a threshold compare stage driving out_mask.
module rgb_hsv_stream #(
  parameter int DATA_W = 8,
  parameter int USER_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  rgb_hsv_stream_if.slave bus
);
  localparam int SR_W = 2 * DATA_W;
  localparam int HQ_W = (DATA_W < 6) ? 6 : DATA_W;
  localparam int HR_W = DATA_W + HQ_W;
  localparam logic [1:0] DOM_R = 2'd0;
  localparam logic [1:0] DOM_G = 2'd1;
  localparam logic [1:0] DOM_B = 2'd2;

  // Narrow builds need 6 hue quotient bits in DATA_W stages: surplus MSBs resolve in stage 1.
  function automatic int h_bit_stage(input int j);
    return (j >= DATA_W) ? 1 : DATA_W - j;
  endfunction

  logic              valid_reg [0:DATA_W];
  logic [USER_W-1:0] user_reg  [0:DATA_W];
  logic [DATA_W-1:0] max_reg   [0:DATA_W];
  logic [DATA_W-1:0] delta_reg [0:DATA_W];
  logic [1:0]        dom_reg   [0:DATA_W];
  logic              neg_reg   [0:DATA_W];
  logic [SR_W-1:0]   s_rem_reg [0:DATA_W];
  logic [DATA_W-1:0] s_q_reg   [0:DATA_W];
  logic [HR_W-1:0]   h_rem_reg [0:DATA_W];
  logic [HQ_W-1:0]   h_q_reg   [0:DATA_W];

  logic en;
  logic out_valid_int;

  assign en           = !out_valid_int || bus.out_ready;
  assign bus.in_ready = en;

  logic [DATA_W-1:0] max_next;
  logic [DATA_W-1:0] min_next;
  logic [DATA_W-1:0] delta_next;
  logic [1:0]        dom_next;
  logic [DATA_W-1:0] num_a;
  logic [DATA_W-1:0] num_c;
  logic              neg_next;
  logic [DATA_W-1:0] abs_num;

  always_comb begin
    max_next = bus.in_r;
    dom_next = DOM_R;
    if (bus.in_g > max_next) begin
      max_next = bus.in_g;
      dom_next = DOM_G;
    end
    if (bus.in_b > max_next) begin
      max_next = bus.in_b;
      dom_next = DOM_B;
    end
    min_next = bus.in_r;
    if (bus.in_g < min_next) min_next = bus.in_g;
    if (bus.in_b < min_next) min_next = bus.in_b;
    delta_next = max_next - min_next;
    case (dom_next)
      DOM_R:   begin num_a = bus.in_g; num_c = bus.in_b; end
      DOM_G:   begin num_a = bus.in_b; num_c = bus.in_r; end
      default: begin num_a = bus.in_r; num_c = bus.in_g; end
    endcase
    neg_next = num_a < num_c;
    abs_num  = neg_next ? (num_c - num_a) : (num_a - num_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg[0] <= 1'b0;
      user_reg[0]  <= '0;
      max_reg[0]   <= '0;
      delta_reg[0] <= '0;
      dom_reg[0]   <= DOM_R;
      neg_reg[0]   <= 1'b0;
      s_rem_reg[0] <= '0;
      s_q_reg[0]   <= '0;
      h_rem_reg[0] <= '0;
      h_q_reg[0]   <= '0;
    end else if (en) begin
      valid_reg[0] <= bus.in_valid;
      user_reg[0]  <= bus.in_user;
      max_reg[0]   <= max_next;
      delta_reg[0] <= delta_next;
      dom_reg[0]   <= dom_next;
      neg_reg[0]   <= neg_next;
      s_rem_reg[0] <= (SR_W'(delta_next) << DATA_W) - SR_W'(delta_next);
      s_q_reg[0]   <= '0;
      h_rem_reg[0] <= HR_W'(abs_num) * HR_W'(60);
      h_q_reg[0]   <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= DATA_W; gi++) begin : g_div
      localparam int SB = DATA_W - gi;
      logic [SR_W-1:0]   s_sub;
      logic [SR_W-1:0]   s_rem_next;
      logic [DATA_W-1:0] s_q_next;
      logic [HR_W-1:0]   h_sub;
      logic [HR_W-1:0]   h_rem_next;
      logic [HQ_W-1:0]   h_q_next;

      always_comb begin
        s_rem_next = s_rem_reg[gi-1];
        s_q_next   = s_q_reg[gi-1];
        s_sub      = SR_W'(max_reg[gi-1]) << SB;
        if (s_rem_next >= s_sub) begin
          s_rem_next   = s_rem_next - s_sub;
          s_q_next[SB] = 1'b1;
        end
        h_rem_next = h_rem_reg[gi-1];
        h_q_next   = h_q_reg[gi-1];
        h_sub      = '0;
        for (int j = HQ_W - 1; j >= 0; j--) begin
          if (h_bit_stage(j) == gi) begin
            h_sub = HR_W'(delta_reg[gi-1]) << j;
            if (h_rem_next >= h_sub) begin
              h_rem_next  = h_rem_next - h_sub;
              h_q_next[j] = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg[gi] <= 1'b0;
          user_reg[gi]  <= '0;
          max_reg[gi]   <= '0;
          delta_reg[gi] <= '0;
          dom_reg[gi]   <= DOM_R;
          neg_reg[gi]   <= 1'b0;
          s_rem_reg[gi] <= '0;
          s_q_reg[gi]   <= '0;
          h_rem_reg[gi] <= '0;
          h_q_reg[gi]   <= '0;
        end else if (en) begin
          valid_reg[gi] <= valid_reg[gi-1];
          user_reg[gi]  <= user_reg[gi-1];
          max_reg[gi]   <= max_reg[gi-1];
          delta_reg[gi] <= delta_reg[gi-1];
          dom_reg[gi]   <= dom_reg[gi-1];
          neg_reg[gi]   <= neg_reg[gi-1];
          s_rem_reg[gi] <= s_rem_next;
          s_q_reg[gi]   <= s_q_next;
          h_rem_reg[gi] <= h_rem_next;
          h_q_reg[gi]   <= h_q_next;
        end
      end
    end
  endgenerate

  int                fin_hue;
  logic [8:0]        fin_h_next;
  logic [DATA_W-1:0] fin_s_next;
  logic              fin_valid_reg;
  logic [8:0]        fin_h_reg;
  logic [DATA_W-1:0] fin_s_reg;
  logic [DATA_W-1:0] fin_v_reg;
  logic [USER_W-1:0] fin_user_reg;

  // Grey pixels (delta=0) never trust the dividers, which ran against a zero divisor.
  always_comb begin
    fin_s_next = s_q_reg[DATA_W];
    case (dom_reg[DATA_W])
      DOM_G:   fin_hue = 120;
      DOM_B:   fin_hue = 240;
      default: fin_hue = 0;
    endcase
    if (neg_reg[DATA_W]) fin_hue = fin_hue - int'(h_q_reg[DATA_W]);
    else                 fin_hue = fin_hue + int'(h_q_reg[DATA_W]);
    if (fin_hue < 0)    fin_hue = fin_hue + 360;
    if (fin_hue == 360) fin_hue = 0;
    if (delta_reg[DATA_W] == '0) begin
      fin_hue    = 0;
      fin_s_next = '0;
    end
    fin_h_next = 9'(fin_hue);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fin_valid_reg <= 1'b0;
      fin_h_reg     <= '0;
      fin_s_reg     <= '0;
      fin_v_reg     <= '0;
      fin_user_reg  <= '0;
    end else if (en) begin
      fin_valid_reg <= valid_reg[DATA_W];
      fin_h_reg     <= fin_h_next;
      fin_s_reg     <= fin_s_next;
      fin_v_reg     <= max_reg[DATA_W];
      fin_user_reg  <= user_reg[DATA_W];
    end
  end

`ifdef HSV_MASK_EN
  logic              hue_in;
  logic              mask_next;
  logic              msk_valid_reg;
  logic [8:0]        msk_h_reg;
  logic [DATA_W-1:0] msk_s_reg;
  logic [DATA_W-1:0] msk_v_reg;
  logic [USER_W-1:0] msk_user_reg;
  logic              mask_reg;

  // lo > hi describes a hue band that wraps through 0 degrees.
  always_comb begin
    if (bus.th_h_lo <= bus.th_h_hi)
      hue_in = (fin_h_reg >= bus.th_h_lo) && (fin_h_reg <= bus.th_h_hi);
    else
      hue_in = (fin_h_reg >= bus.th_h_lo) || (fin_h_reg <= bus.th_h_hi);
    mask_next = hue_in && (fin_s_reg >= bus.th_s_lo) && (fin_v_reg >= bus.th_v_lo);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msk_valid_reg <= 1'b0;
      msk_h_reg     <= '0;
      msk_s_reg     <= '0;
      msk_v_reg     <= '0;
      msk_user_reg  <= '0;
      mask_reg      <= 1'b0;
    end else if (en) begin
      msk_valid_reg <= fin_valid_reg;
      msk_h_reg     <= fin_h_reg;
      msk_s_reg     <= fin_s_reg;
      msk_v_reg     <= fin_v_reg;
      msk_user_reg  <= fin_user_reg;
      mask_reg      <= mask_next;
    end
  end

  assign out_valid_int = msk_valid_reg;
  assign bus.out_h     = msk_h_reg;
  assign bus.out_s     = msk_s_reg;
  assign bus.out_v     = msk_v_reg;
  assign bus.out_user  = msk_user_reg;
  assign bus.out_mask  = mask_reg;
`else
  assign out_valid_int = fin_valid_reg;
  assign bus.out_h     = fin_h_reg;
  assign bus.out_s     = fin_s_reg;
  assign bus.out_v     = fin_v_reg;
  assign bus.out_user  = fin_user_reg;
`endif
  assign bus.out_valid = out_valid_int;
endmodule
